// File: rtl/mult_share_ctrl_if.sv
// Launch/ready handshake between the shared-multiplier controller (master)
// and the multi-cycle multiplier (slave).
interface mult_share_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               mult_start;
    logic               mult_sign;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic               mult_ready;
    logic [2*WIDTH-1:0] mult_product;

    modport master (
        output mult_start,
        output mult_sign,
        output mult_a,
        output mult_b,
        input  mult_ready,
        input  mult_product
    );

    modport slave (
        input  mult_start,
        input  mult_sign,
        input  mult_a,
        input  mult_b,
        output mult_ready,
        output mult_product
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Shares one multi-cycle multiplier between the two execute lanes: arbitrates
// requests, launches the multiplier, holds each lane's product and raises stalls.
module mult_share_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic                sign0,
    input  logic                sign1,
    input  logic [WIDTH-1:0]    a0,
    input  logic [WIDTH-1:0]    b0,
    input  logic [WIDTH-1:0]    a1,
    input  logic [WIDTH-1:0]    b1,
    input  logic                advance,
    input  logic                flush,
    mult_share_ctrl_if.master   mult_if,
    output logic                done0,
    output logic                done1,
    output logic [2*WIDTH-1:0]  result0,
    output logic [2*WIDTH-1:0]  result1,
    output logic                stall0,
    output logic                stall1,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               served0_q, served0_d;
    logic               served1_q, served1_d;
    logic               start_q, start_d;
    op_t                op_q, op_d;
    logic [2*WIDTH-1:0] result0_q, result0_d;
    logic [2*WIDTH-1:0] result1_q, result1_d;

    logic pend0, pend1;
    logic capture;
    logic done0_c, done1_c;

    // A flush in the same cycle as mult_ready throws the product away.
    always_comb begin
        pend0   = req0 & ~served0_q;
        pend1   = req1 & ~served1_q;
        capture = (state_q == BUSY) & mult_if.mult_ready & ~flush;
        done0_c = capture & ~owner_q;
        done1_c = capture &  owner_q;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d   = state_q;
        owner_d   = owner_q;
        start_d   = 1'b0;
        op_d      = op_q;
        result0_d = result0_q;
        result1_d = result1_q;

        case (state_q)
            IDLE: begin
                if (!flush && (pend0 || pend1)) begin
                    owner_d = ~pend0;
                    start_d = 1'b1;
                    state_d = BUSY;
                    if (pend0) begin
                        op_d = '{sign: sign0, a: a0, b: b0};
                    end else begin
                        op_d = '{sign: sign1, a: a1, b: b1};
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = mult_if.mult_ready ? IDLE : DRAIN;
                end else if (mult_if.mult_ready) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (mult_if.mult_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done0_c) result0_d = mult_if.mult_product;
        if (done1_c) result1_d = mult_if.mult_product;
    end

    // done wins over the advance clear so a lane finishing on an advance cycle
    // still reads as served for the following cycle.
    always_comb begin
        served0_d = served0_q;
        served1_d = served1_q;
        if (flush) begin
            served0_d = 1'b0;
            served1_d = 1'b0;
        end else begin
            if (done0_c)      served0_d = 1'b1;
            else if (advance) served0_d = 1'b0;
            if (done1_c)      served1_d = 1'b1;
            else if (advance) served1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            served0_q <= 1'b0;
            served1_q <= 1'b0;
            start_q   <= 1'b0;
            op_q      <= '0;
            result0_q <= '0;
            result1_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            owner_q   <= owner_d;
            served0_q <= served0_d;
            served1_q <= served1_d;
            start_q   <= start_d;
            op_q      <= op_d;
            result0_q <= result0_d;
            result1_q <= result1_d;
        end
    end

    always_comb begin
        mult_if.mult_start = start_q;
        mult_if.mult_sign  = op_q.sign;
        mult_if.mult_a     = op_q.a;
        mult_if.mult_b     = op_q.b;
        done0              = done0_c;
        done1              = done1_c;
        result0            = result0_q;
        result1            = result1_q;
        stall0             = pend0 & ~done0_c;
        stall1             = pend1 & ~done1_c;
        busy               = (state_q != IDLE);
    end

    a_done_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(done0_c && done1_c));

    a_start_only_in_busy: assert property (@(posedge clk) disable iff (reset)
        start_q |-> (state_q == BUSY));

endmodule
